// File: rtl/nn_pkg.sv
// Shared constants and types for the classifier output stage.
package nn_pkg;

  localparam int NN_SCORE_W = 8;
  localparam int NN_CLASSES = 10;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } argmax_state_t;

endpackage : nn_pkg

// File: rtl/argmax_stream_score_gt.sv
// Strict greater-than on two scores, unsigned or two's complement by parameter.
module score_gt #(
  parameter int DATA_W = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              gt_o
);

  generate
    if (SIGNED) begin : g_signed
      assign gt_o = $signed(a_i) > $signed(b_i);
    end else begin : g_unsigned
      assign gt_o = a_i > b_i;
    end
  endgenerate

endmodule : score_gt

// File: rtl/argmax_stream.sv
// Serial argmax over a valid/ready score stream; one registered result per vector.
//   state | meaning
//   ACC   | accepting scores, tracking running max and its index
//   DONE  | holding the result until the consumer takes it
module argmax_stream
  import nn_pkg::*;
#(
  parameter int DATA_W = NN_SCORE_W,
  parameter int MAX_N  = 16,
  parameter int IDX_W  = $clog2(MAX_N),
  parameter bit SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [DATA_W-1:0] out_max,
  output logic [IDX_W:0]    out_count,
  output logic              out_ovf
);

  argmax_state_t     state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  oidx_q, oidx_d;
  logic [DATA_W-1:0] omax_q, omax_d;
  logic [IDX_W:0]    ocnt_q, ocnt_d;
  logic              oovf_q, oovf_d;

  logic accept;
  logic first;
  logic at_cap;
  logic gt;

  score_gt #(
    .DATA_W (DATA_W),
    .SIGNED (SIGNED)
  ) u_gt (
    .a_i  (in_data),
    .b_i  (max_q),
    .gt_o (gt)
  );

  assign accept = in_valid && (state_q == ACC);
  assign first  = (cnt_q == '0);
  assign at_cap = (cnt_q == IDX_W'(MAX_N - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    idx_d   = idx_q;
    oidx_d  = oidx_q;
    omax_d  = omax_q;
    ocnt_d  = ocnt_q;
    oovf_d  = oovf_q;
    if (accept) begin
      cnt_d = cnt_q + 1'b1;
      if (first || gt) begin
        max_d = in_data;
        idx_d = first ? '0 : cnt_q;
      end
      // Terminating beat is folded into the result; cnt restarts so overflow leftovers form a new vector.
      if (in_last || at_cap) begin
        state_d = DONE;
        cnt_d   = '0;
        oidx_d  = idx_d;
        omax_d  = max_d;
        ocnt_d  = {1'b0, cnt_q} + 1'b1;
        oovf_d  = at_cap && !in_last;
      end
    end else if ((state_q == DONE) && out_ready) begin
      state_d = ACC;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      cnt_q   <= '0;
      max_q   <= '0;
      idx_q   <= '0;
      oidx_q  <= '0;
      omax_q  <= '0;
      ocnt_q  <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      oidx_q  <= oidx_d;
      omax_q  <= omax_d;
      ocnt_q  <= ocnt_d;
      oovf_q  <= oovf_d;
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == DONE);
  assign out_idx   = oidx_q;
  assign out_max   = omax_q;
  assign out_count = ocnt_q;
  assign out_ovf   = oovf_q;

endmodule : argmax_stream

// File: tb/tb_argmax_stream.sv
// Three argmax_stream configurations (unsigned/16, signed/16, unsigned/4) checked
// every cycle against a queue-based argmax model, plus literal vector results.
module tb_argmax_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv[3];
  logic       il[3];
  logic       ordy[3];
  logic [7:0] id[3];
  logic       ir[3];
  logic       ov[3];
  logic       oovf[3];
  logic [7:0] omax[3];
  logic [3:0] oidx0, oidx1;
  logic [1:0] oidx2;
  logic [4:0] ocnt0, ocnt1;
  logic [2:0] ocnt2;

  always #5 clk = ~clk;

  argmax_stream #(.DATA_W(8), .MAX_N(16), .SIGNED(1'b0)) u_uns (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .in_last(il[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_idx(oidx0),
    .out_max(omax[0]), .out_count(ocnt0), .out_ovf(oovf[0]));

  argmax_stream #(.DATA_W(8), .MAX_N(16), .SIGNED(1'b1)) u_sgn (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .in_last(il[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_idx(oidx1),
    .out_max(omax[1]), .out_count(ocnt1), .out_ovf(oovf[1]));

  argmax_stream #(.DATA_W(8), .MAX_N(4), .SIGNED(1'b0)) u_ovf (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
    .in_last(il[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_idx(oidx2),
    .out_max(omax[2]), .out_count(ocnt2), .out_ovf(oovf[2]));

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;
  bit rnd_or = 1'b0;

  int maxn[3] = '{16, 16, 4};
  bit sgnd[3] = '{1'b0, 1'b1, 1'b0};

  // Model state: scores of the vector in flight and the result awaiting handoff.
  int vec[3][$];
  bit pend[3] = '{1'b0, 1'b0, 1'b0};
  int e_idx[3], e_max[3], e_cnt[3], e_ovf[3];
  int best;

  task automatic chk(string nm, int k, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s inst%0d t=%0t got %0d expected %0d", nm, k, $time, act, exp);
  endtask

  function automatic int g_idx(int k);
    case (k)
      0: return int'(oidx0);
      1: return int'(oidx1);
      default: return int'(oidx2);
    endcase
  endfunction

  function automatic int g_cnt(int k);
    case (k)
      0: return int'(ocnt0);
      1: return int'(ocnt1);
      default: return int'(ocnt2);
    endcase
  endfunction

  function automatic bit gt(int k, int a, int b);
    logic signed [7:0] sa, sb;
    sa = a[7:0];
    sb = b[7:0];
    if (sgnd[k]) return sa > sb;
    return a > b;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        vec[k].delete();
        pend[k] = 1'b0;
      end else if (pend[k]) begin
        if (ordy[k]) pend[k] = 1'b0;
      end else if (iv[k]) begin
        vec[k].push_back(int'(id[k]));
        if (il[k] || vec[k].size() == maxn[k]) begin
          best = 0;
          for (int i = 1; i < vec[k].size(); i++)
            if (gt(k, vec[k][i], vec[k][best])) best = i;
          e_idx[k] = best;
          e_max[k] = vec[k][best];
          e_cnt[k] = vec[k].size();
          e_ovf[k] = il[k] ? 0 : 1;
          pend[k]  = 1'b1;
          vec[k].delete();
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_or) for (int k = 0; k < 3; k++) ordy[k] = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      for (int k = 0; k < 3; k++) begin
        chk("cyc_in_ready", k, int'(ir[k]), int'(!pend[k]));
        chk("cyc_out_valid", k, int'(ov[k]), int'(pend[k]));
        if (pend[k]) begin
          chk("cyc_out_idx", k, g_idx(k), e_idx[k]);
          chk("cyc_out_max", k, int'(omax[k]), e_max[k]);
          chk("cyc_out_count", k, g_cnt(k), e_cnt[k]);
          chk("cyc_out_ovf", k, int'(oovf[k]), e_ovf[k]);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send(int k, int d, bit l, int gap);
    int t;
    repeat ($urandom_range(0, gap)) begin
      @(posedge clk);
      #1;
    end
    iv[k] = 1'b1;
    id[k] = 8'(d);
    il[k] = l;
    t = 0;
    forever begin
      @(negedge clk);
      if (ir[k]) break;
      t++;
      if (t > 1000) begin
        chk("send_timeout", k, 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
    il[k] = 1'b0;
  endtask

  // Waits (bounded) for out_valid and checks DUT and model against literal values.
  task automatic lit(int k, int xi, int xm, int xc, int xo);
    int t;
    t = 0;
    while (!ov[k] && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("lit_valid", k, int'(ov[k]), 1);
    chk("lit_idx", k, g_idx(k), xi);
    chk("lit_max", k, int'(omax[k]), xm);
    chk("lit_count", k, g_cnt(k), xc);
    chk("lit_ovf", k, int'(oovf[k]), xo);
    chk("model_idx", k, e_idx[k], xi);
    chk("model_max", k, e_max[k], xm);
    chk("model_count", k, e_cnt[k], xc);
  endtask

  task automatic release_res(int k);
    ordy[k] = 1'b1;
    @(posedge clk);
    #1;
    ordy[k] = 1'b0;
  endtask

  int tv10[10] = '{3, 7, 200, 9, 200, 1, 0, 5, 4, 2};
  int sv5[5] = '{8'h80, 8'hFF, 8'h05, 8'h7F, 8'h10};
  int ov6[6] = '{1, 2, 3, 9, 8, 7};
  int hi, hm, hc, ho, len;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; il[k] = 1'b0; id[k] = 8'h00; ordy[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", k, int'(ir[k]), 1);
      chk("rst_out_valid", k, int'(ov[k]), 0);
      chk("rst_out_idx", k, g_idx(k), 0);
      chk("rst_out_max", k, int'(omax[k]), 0);
      chk("rst_out_count", k, g_cnt(k), 0);
      chk("rst_out_ovf", k, int'(oovf[k]), 0);
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) send(0, tv10[i], i == 9, 0);
    @(negedge clk);
    chk("latency_valid", 0, int'(ov[0]), 1);
    lit(0, 2, 200, 10, 0);
    release_res(0);

    for (int i = 0; i < 5; i++) send(1, sv5[i], i == 4, 1);
    lit(1, 3, 8'h7F, 5, 0);
    release_res(1);
    send(1, 8'h80, 1'b0, 0);
    send(1, 8'hFF, 1'b1, 0);
    lit(1, 1, 8'hFF, 2, 0);
    release_res(1);

    for (int i = 0; i < 4; i++) send(2, ov6[i], 1'b0, 0);
    lit(2, 3, 9, 4, 1);
    release_res(2);
    for (int i = 4; i < 6; i++) send(2, ov6[i], i == 5, 0);
    lit(2, 0, 8, 2, 0);
    release_res(2);

    for (int i = 0; i < 10; i++) send(0, 8'h42, i == 9, 1);
    lit(0, 0, 8'h42, 10, 0);
    release_res(0);
    send(0, 8'h00, 1'b1, 0);
    lit(0, 0, 0, 1, 0);
    release_res(0);

    // Backpressure with junk beats offered while the result is held.
    send(0, 10, 1'b0, 0);
    send(0, 50, 1'b0, 0);
    send(0, 20, 1'b1, 0);
    lit(0, 1, 50, 3, 0);
    hi = g_idx(0); hm = int'(omax[0]); hc = g_cnt(0); ho = int'(oovf[0]);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      iv[0] = 1'($urandom_range(0, 1));
      id[0] = 8'($urandom);
      il[0] = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("bp_in_ready", 0, int'(ir[0]), 0);
      chk("bp_valid", 0, int'(ov[0]), 1);
      chk("bp_idx", 0, g_idx(0), hi);
      chk("bp_max", 0, int'(omax[0]), hm);
      chk("bp_count", 0, g_cnt(0), hc);
      chk("bp_ovf", 0, int'(oovf[0]), ho);
    end
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    il[0] = 1'b0;
    release_res(0);
    @(negedge clk);
    chk("bp_ready_after", 0, int'(ir[0]), 1);
    chk("bp_valid_after", 0, int'(ov[0]), 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) send(0, 100 + i, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", 0, int'(ir[0]), 1);
    chk("mid_rst_valid", 0, int'(ov[0]), 0);
    chk("mid_rst_count", 0, g_cnt(0), 0);
    @(posedge clk);
    #1;
    send(0, 5, 1'b0, 0);
    send(0, 6, 1'b1, 0);
    lit(0, 1, 6, 2, 0);
    release_res(0);

    rnd_or = 1'b1;
    for (int v = 0; v < 25; v++) begin
      for (int k = 0; k < 3; k++) begin
        len = $urandom_range(1, maxn[k] + 2);
        for (int b = 0; b < len; b++)
          send(k, (k == 2) ? $urandom_range(0, 7) : $urandom_range(0, 255), b == len - 1, 2);
      end
    end
    rnd_or = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) ordy[k] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("drain_valid", k, int'(ov[k]), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_argmax_stream
